// File: rtl/tmds_video_sequencer.sv
// rtl/tmds_video_sequencer.sv - raster timing sequencer with early pixel fetch and aligned TMDS control outputs
module tmds_video_sequencer #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit SYNC_POL = 1'b1,
  parameter int LEAD     = 2
) (
  input  logic        pixclk,
  input  logic        reset,
  input  logic        en,
  output logic        pix_req,
  output logic [10:0] req_x,
  output logic [9:0]  req_y,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        running
);

  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Pipeline tuple: {de, hsync level, vsync level, x, y, frame_start}
  localparam int PW = 25;
  localparam logic [PW-1:0] IDLE_TUPLE = {1'b0, ~SYNC_POL, ~SYNC_POL, 11'd0, 10'd0, 1'b0};

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [10:0]   h;
  logic [9:0]    v;
  logic          at_frame_end;
  logic          hs_active;
  logic          vs_active;
  logic          fs_raw;
  logic [PW-1:0] pipe_in;
  logic [PW-1:0] pipe [LEAD];

  assign at_frame_end = (h == H_LAST) && (v == V_LAST);
  assign running      = (state != S_IDLE);

  // Start on any cycle from IDLE; stop only after the last cycle of a frame
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (en) state_next = S_RUN;
      S_RUN:   if (!en) state_next = S_DRAIN;
      S_DRAIN: begin
        if (en) state_next = S_RUN;
        else if (at_frame_end) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Raster counters: held at the origin while idle, free-running otherwise
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (state == S_IDLE) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 10'd1;
    end else begin
      h <= h + 11'd1;
    end
  end

  // Request stage: issued LEAD cycles ahead of the matching de
  assign pix_req = running && (h < H_ACT) && (v < V_ACT);
  assign req_x   = pix_req ? h : '0;
  assign req_y   = pix_req ? v : '0;

  assign hs_active = (h >= HS_START) && (h < HS_END);
  assign vs_active = (v >= VS_START) && (v < VS_END);
  assign fs_raw    = running && (h == '0) && (v == '0);

  assign pipe_in = running ? {pix_req,
                              hs_active ? SYNC_POL : ~SYNC_POL,
                              vs_active ? SYNC_POL : ~SYNC_POL,
                              h, v, fs_raw}
                           : IDLE_TUPLE;

  // Output alignment pipeline, flushed to the idle tuple on reset
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LEAD; i++) pipe[i] <= IDLE_TUPLE;
    end else begin
      pipe[0] <= pipe_in;
      for (int i = 1; i < LEAD; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {de, hsync, vsync, x, y, frame_start} = pipe[LEAD-1];

endmodule

// File: tb/tb_tmds_video_sequencer.sv
// tb/tb_tmds_video_sequencer.sv - self-checking bench for tmds_video_sequencer on a reduced raster
module tb_tmds_video_sequencer;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam bit SYNC_POL = 1'b1;
  localparam int LEAD     = 2;
  localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = HT * VT;

  typedef struct packed {
    logic        pix_req;
    logic [10:0] req_x;
    logic [9:0]  req_y;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [10:0] x;
    logic [9:0]  y;
    logic        fs;
    logic        running;
  } obs_t;

  typedef struct {
    logic en;
    obs_t exp;
  } vec_t;

  logic        pixclk = 1'b0;
  logic        reset;
  logic        en;
  logic        pix_req;
  logic [10:0] req_x;
  logic [9:0]  req_y;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic [10:0] x;
  logic [9:0]  y;
  logic        frame_start;
  logic        running;
  obs_t        act;

  int checks = 0;
  int errors = 0;

  tmds_video_sequencer #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL), .LEAD(LEAD)
  ) dut (
    .pixclk(pixclk), .reset(reset), .en(en),
    .pix_req(pix_req), .req_x(req_x), .req_y(req_y),
    .de(de), .hsync(hsync), .vsync(vsync), .x(x), .y(y),
    .frame_start(frame_start), .running(running)
  );

  assign act = {pix_req, req_x, req_y, de, hsync, vsync, x, y, frame_start, running};

  always #5 pixclk = ~pixclk;

  // Reference model: frame position as a flat cycle index, outputs delayed by a queue
  bit   m_run;
  bit   m_en_prev;
  int   m_p;
  obs_t m_pipe[$];
  obs_t idle_obs;

  function automatic string fmt(input obs_t o);
    return $sformatf("req=%0b rx=%0d ry=%0d de=%0b hs=%0b vs=%0b x=%0d y=%0d fs=%0b run=%0b",
                     o.pix_req, o.req_x, o.req_y, o.de, o.hsync, o.vsync, o.x, o.y, o.fs, o.running);
  endfunction

  function automatic obs_t model_raw();
    obs_t o;
    int hh, vv;
    o  = '0;
    hh = m_run ? m_p % HT : 0;
    vv = m_run ? m_p / HT : 0;
    o.running = m_run;
    o.pix_req = m_run && hh < H_ACTIVE && vv < V_ACTIVE;
    if (o.pix_req) begin
      o.req_x = 11'(hh);
      o.req_y = 10'(vv);
    end
    o.de    = o.pix_req;
    o.hsync = (m_run && hh >= H_ACTIVE + H_FP && hh < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : !SYNC_POL;
    o.vsync = (m_run && vv >= V_ACTIVE + V_FP && vv < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : !SYNC_POL;
    o.x     = 11'(hh);
    o.y     = 10'(vv);
    o.fs    = m_run && m_p == 0;
    return o;
  endfunction

  function automatic obs_t model_out();
    obs_t o, d;
    o = model_raw();
    d = m_pipe[0];
    o.de = d.de; o.hsync = d.hsync; o.vsync = d.vsync;
    o.x  = d.x;  o.y     = d.y;     o.fs    = d.fs;
    return o;
  endfunction

  task automatic model_reset();
    m_run = 0; m_en_prev = 0; m_p = 0;
    m_pipe.delete();
    for (int i = 0; i < LEAD; i++) m_pipe.push_back(idle_obs);
  endtask

  task automatic model_advance(input logic en_v);
    m_pipe.push_back(model_raw());
    void'(m_pipe.pop_front());
    if (!m_run) begin
      if (en_v) begin m_run = 1; m_p = 0; end
    end else if (m_p == FRAME - 1 && !en_v && !m_en_prev) begin
      m_run = 0; m_p = 0;
    end else begin
      m_p = (m_p + 1) % FRAME;
    end
    m_en_prev = en_v;
  endtask

  task automatic cmp(input string name, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(a), fmt(e));
    end
  endtask

  task automatic cmp_int(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic tick(input logic en_v);
    en = en_v;
    @(posedge pixclk);
    model_advance(en_v);
    #1;
    cmp("model", act, model_out());
  endtask

  task automatic do_reset(input logic en_v);
    en = en_v;
    reset = 1'b1;
    #1;
    model_reset();
    cmp("reset_async", act, idle_obs);
    @(posedge pixclk);
    #1;
    reset = 1'b0;
    cmp("reset_hold", act, model_out());
  endtask

  task automatic seek_pos(input int p);
    for (int i = 0; i < 2 * FRAME && !(m_run && m_p == p); i++) tick(1'b1);
    cmp_int("seek_pos", int'(m_run && m_p == p), 1);
  endtask

  task automatic seek_fs();
    for (int i = 0; i < 2 * FRAME && !frame_start; i++) tick(1'b1);
    cmp_int("seek_fs", int'(frame_start), 1);
  endtask

  vec_t vecs[16];
  logic de_s[FRAME+1];
  logic hs_s[FRAME+1];
  logic vs_s[FRAME+1];
  logic fs_s[FRAME+1];
  int   y_s[FRAME+1];

  initial begin
    int n, cnt, first, last_y, fs_cnt, low_cnt;
    logic e_v;
    obs_t e;

    idle_obs = '0;
    idle_obs.hsync = !SYNC_POL;
    idle_obs.vsync = !SYNC_POL;
    reset = 1'b1;
    en = 1'b0;

    // Start-up table: en rises at cycle 10 after reset release
    for (int i = 0; i < 16; i++) begin
      vecs[i].en  = (i >= 10);
      vecs[i].exp = idle_obs;
    end
    for (int i = 11; i < 16; i++) begin
      vecs[i].exp.pix_req = 1'b1;
      vecs[i].exp.req_x   = 11'(i - 11);
      vecs[i].exp.running = 1'b1;
    end
    for (int i = 13; i < 16; i++) begin
      vecs[i].exp.de = 1'b1;
      vecs[i].exp.x  = 11'(i - 13);
    end
    vecs[13].exp.fs = 1'b1;

    do_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      cmp($sformatf("table[%0d]", i), act, vecs[i].exp);
      tick(vecs[i].en);
    end

    // One full frame captured from a frame_start pulse
    seek_fs();
    for (int k = 0; k <= FRAME; k++) begin
      de_s[k] = de; hs_s[k] = hsync; vs_s[k] = vsync; fs_s[k] = frame_start; y_s[k] = int'(y);
      if (k < FRAME) tick(1'b1);
    end
    cnt = 0; for (int k = 0; k < FRAME; k++) if (de_s[k]) cnt++;
    cmp_int("de_per_frame", cnt, H_ACTIVE * V_ACTIVE);
    cnt = 0; for (int k = 0; k < HT; k++) if (de_s[k]) cnt++;
    cmp_int("de_per_line", cnt, H_ACTIVE);
    cnt = 0; for (int k = 0; k < HT; k++) if (hs_s[k] == SYNC_POL) cnt++;
    cmp_int("hsync_width", cnt, H_SYNC);
    first = -1; for (int k = HT - 1; k >= 0; k--) if (hs_s[k] == SYNC_POL) first = k;
    cmp_int("hsync_offset", first, H_ACTIVE + H_FP);
    cmp_int("line2_y", y_s[HT], 1);
    cmp_int("line2_de", int'(de_s[HT]), 1);
    cnt = 0; for (int k = 0; k < FRAME; k++) if (vs_s[k] == SYNC_POL) cnt++;
    cmp_int("vsync_width", cnt, V_SYNC * HT);
    first = -1; for (int k = FRAME - 1; k >= 0; k--) if (vs_s[k] == SYNC_POL) first = k;
    cmp_int("vsync_offset", first, (V_ACTIVE + V_FP) * HT);
    cnt = 0; for (int k = 1; k < FRAME; k++) if (fs_s[k]) cnt++;
    cmp_int("fs_inside_frame", cnt, 0);
    cmp_int("fs_period", int'(fs_s[FRAME]), 1);

    // Drain: en drops mid-frame, frame completes, then idle
    seek_pos(2 * HT + 5);
    n = 0; last_y = -1;
    do begin
      tick(1'b0);
      n++;
      if (de) last_y = int'(y);
    end while (running && n < 2 * FRAME);
    cmp_int("drain_cycles", n, FRAME - (2 * HT + 5));
    cmp_int("drain_last_de_row", last_y, V_ACTIVE - 1);
    cnt = 0;
    for (int i = 0; i < LEAD + 6; i++) begin
      tick(1'b0);
      if (pix_req || de) cnt++;
    end
    cmp_int("no_req_after_drain", cnt, 0);
    cmp("idle_after_drain", act, idle_obs);

    // en dips during a frame and returns: raster must stay continuous
    tick(1'b1);
    seek_fs();
    fs_cnt = 0; low_cnt = 0;
    for (int k = 1; k <= FRAME; k++) begin
      tick((k >= 2 * HT && k < 3 * HT) ? 1'b0 : 1'b1);
      if (!running) low_cnt++;
      if (k < FRAME && frame_start) fs_cnt++;
    end
    cmp_int("gap_running_low", low_cnt, 0);
    cmp_int("gap_extra_fs", fs_cnt, 0);
    cmp_int("gap_fs_period", int'(frame_start), 1);

    // Reset mid-frame with en held high
    seek_pos(2 * HT + 5);
    do_reset(1'b1);
    tick(1'b1);
    e = idle_obs; e.pix_req = 1'b1; e.running = 1'b1;
    cmp("restart_origin", act, e);

    // Randomized en segments with occasional resets
    for (int s = 0; s < 40; s++) begin
      e_v = 1'(($urandom_range(0, 3) != 0));
      n   = int'($urandom_range(1, 150));
      if ($urandom_range(0, 11) == 0) do_reset(1'(($urandom_range(0, 1))));
      for (int i = 0; i < n; i++) tick(e_v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_video_sequencer.md
# tmds_video_sequencer

Video timing sequencer for the TMDS serializer path. It generates the 800x600@60 (40 MHz) raster and issues per-pixel fetch requests to the renderer a fixed number of cycles early. It then presents the aligned DE/HSYNC/VSYNC and pixel coordinates to the TMDS encoders, so encoded symbols reach the serializer in raster order. It starts and stops only on frame boundaries, so the link never carries a truncated frame.

## Interface
- H_ACTIVE, 800, active pixels per line
- H_FP, 40, horizontal front porch (cycles)
- H_SYNC, 128, horizontal sync width
- H_BP, 88, horizontal back porch
- V_ACTIVE, 600, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width
- V_BP, 23, vertical back porch
- SYNC_POL, 1, active level of hsync/vsync (1 = positive)
- LEAD, 2, cycles between pix_req and matching de (1..7)

Ports:
- pixclk  in  1  pixel clock, 40 MHz; all logic on rising edge
- reset  in  1  asynchronous, active-high
- en  in  1  run request (level)
- pix_req  out  1  renderer fetch strobe for pixel (req_x, req_y)
- req_x  out  11  requested column
- req_y  out  10  requested row
- de  out  1  data enable to encoders
- hsync  out  1  horizontal sync, polarity SYNC_POL
- vsync  out  1  vertical sync, polarity SYNC_POL
- x  out  11  column of pixel currently under de
- y  out  10  row of pixel currently under de
- frame_start  out  1  one-cycle pulse at h=0, v=0 of output timing
- running  out  1  high in RUN or DRAIN

## Operation
- Internal counters h (11 b), v (10 b): h 0..HT-1 with HT = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); v advances when h wraps; v 0..VT-1 with VT = 628. Both wrap to 0. No other arithmetic; all compares unsigned.
- Request stage (undelayed): pix_req = (state != IDLE) & h < H_ACTIVE & v < V_ACTIVE; req_x = h, req_y = v when pix_req, else 0.
- Raw timing per counter position: de_raw = pix_req; hs_raw active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (840..967); vs_raw active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (601..604), across whole lines; fs_raw = running & h==0 & v==0.
- Output stage: de, hsync, vsync, x, y, frame_start are de_raw/hs_raw/vs_raw/h/v/fs_raw delayed exactly LEAD cycles through a shift pipeline. In IDLE, the pipeline input is the idle tuple (de 0, syncs inactive, x = y = 0, fs 0).
- FSM:
  - IDLE: counters held at 0. On en = 1, go to RUN; counting starts in that cycle's next edge, with h = 0, v = 0 in the first RUN cycle.
  - RUN: counters free-run. On en = 0, go to DRAIN.
  - DRAIN: counters free-run. en = 1 returns to RUN with no gap. At h = HT-1, v = VT-1 with en = 0, go to IDLE; counters return to 0.
- running = (state != IDLE), undelayed.
- Reset anywhere: state IDLE, counters 0, pipeline flushed to the idle tuple immediately (asynchronous). A partial frame is acceptable only on reset.

## Timing
- Reset values: pix_req 0, req_x 0, req_y 0, de 0, hsync = vsync = ~SYNC_POL, x 0, y 0, frame_start 0, running 0.
- Renderer contract: pixel data for (req_x, req_y) is valid LEAD-1 cycles after pix_req, so it is registered alongside de.
- pix_req for pixel (c, r) at cycle t implies de = 1 with x = c, y = r at t+LEAD.
- Per line: 800 de cycles, then 40 FP, 128 sync, 88 BP. Frame = 663168 cycles.
- After en rises in IDLE: running = 1 the next cycle; pix_req for (0,0) in the same cycle; frame_start at +LEAD from that cycle.
- After final DRAIN cycle: outputs reach the idle tuple LEAD cycles later.

## Test plan
- Reset, then en = 1 at cycle 10 → pix_req = 1 with req_x = 0, req_y = 0 at cycle 11; de = 1, x = 0, frame_start = 1 at cycle 13 (LEAD = 2).
- Free run, one full line → de high exactly 800 cycles; hsync active for exactly 128 cycles starting 840 cycles after de rise; next line y = 1.
- Full frame → 600 lines with de; vsync active for lines 601..604 (4×1056 cycles); frame_start period 663168 cycles.
- en = 0 at mid-frame (v = 300) → running stays 1, frame completes; running = 0 after the h = 1055, v = 627 cycle; no pix_req afterward; de last high at v = 599.
- en drops at v = 300 and re-rises at v = 400 → no gap, no extra frame_start, raster continuous.
- Reset asserted at v = 200, h = 500 → all outputs at reset values immediately; en still high after release → new frame starts at (0,0) on the cycle after release.
